adc_chan_avg: RTL
=================

# adc_chan_avg

Per-channel decimating averager between the ADC controller and the PID core. Consumes the controller's dual-lane sample stream (lanes A and B, one valid strobe), accumulates 2^avg_log samples per channel, and emits one arithmetic-mean word per channel per averaging window. Completed results from both lanes are serialized through a small dual-write FIFO onto a single valid/ready stream into the PID core.

## Interface
Parameters:
- W_DATA, 18, width of ADC samples and averaged output
- N_CHAN, 8, number of ADC channels
- W_CHS, 3, channel index width
- W_AVG, 3, width of avg_log; max window 2^(2^W_AVG-1) = 128 samples
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2)

Ports:
- clk_in  in  1  system clock (same domain as ADC controller)
- n_reset_in  in  1  reset, asynchronous, active-low
- data_valid_in  in  1  one-cycle strobe: lane A/B samples valid
- chan_a_in  in  W_CHS  lane A channel index
- chan_b_in  in  W_CHS  lane B channel index
- data_a_in  in  W_DATA  lane A sample, signed
- data_b_in  in  W_DATA  lane B sample, signed
- avg_log_in  in  W_AVG  log2 of window length, sampled on avg_update_in
- avg_update_in  in  1  pulse: latch avg_log_in, clear all accumulators
- ready_in  in  1  PID core accepts output word
- data_valid_out  out  1  output word valid (FIFO non-empty)
- chan_out  out  W_CHS  channel of output word
- data_out  out  W_DATA  averaged sample, signed
- overflow_out  out  1  sticky: a completed result was dropped
- collision_out  out  1  sticky: chan_a_in == chan_b_in on a valid strobe

## Operation
- Per channel: signed accumulator acc[c] (W_DATA + 2^W_AVG - 1 bits, sign-extended adds) and sample counter cnt[c] (2^W_AVG - 1 bits).
- On data_valid_in (no avg_update_in): lane A updates channel chan_a_in; lane B updates chan_b_in.
- Sample is last of window when cnt[c] == 2^avg_log - 1: result = (acc[c] + sample) >>> avg_log (arithmetic, truncation toward −∞), low W_DATA bits; push {c, result}; acc[c] ← 0, cnt[c] ← 0. Otherwise acc[c] += sample, cnt[c] += 1.
- avg_log = 0: every sample passes straight through.
- Collision (chan_a_in == chan_b_in): lane A processed, lane B discarded, collision_out set.
- FIFO push order: lane A before lane B when both complete in one cycle.
- FIFO full handling: free slots evaluated including same-cycle pop; 1 slot with 2 results → A kept, B dropped; 0 slots → both dropped; any drop sets overflow_out.
- avg_update_in: avg_log ← avg_log_in, all acc/cnt cleared, overflow_out and collision_out cleared; FIFO contents retained; coincident data_valid_in sample discarded.
- Output: first-word-fall-through; word popped on data_valid_out & ready_in. chan_out/data_out hold steady while data_valid_out & !ready_in.

## Timing
- Reset (n_reset_in low, async): data_valid_out 0, chan_out 0, data_out 0, overflow_out 0, collision_out 0, avg_log 0, all acc/cnt 0, FIFO empty.
- Latency: completing strobe at edge t → data_valid_out high after edge t+1 when FIFO empty.
- Throughput: 2 pushes/cycle max, 1 pop/cycle; simultaneous push and pop on full FIFO accepted (pop frees slot same cycle).
- Reset deassertion mid-window: partial sums lost; windows restart from zero.
- ready_in may be held low indefinitely; only overflow results.

## Structure
- Shared package adc_pkg: W_DATA, N_CHAN, W_CHS, W_AVG constants; accumulator width function; {chan, data} result struct.
- Sub-module sample_fifo_2w1r: 2-write/1-read FWFT FIFO with per-write accept outputs; averager core drives it.

## Test plan
- avg_log=0, strobe A=ch0 +5, B=ch4 −3, ready_in=1 → outputs (0,+5) then (4,−3), data_valid_out first high one cycle after strobe.
- avg_log=2, ch1 samples 1,2,3,5 → single output (1,2) after 4th strobe; ch1 samples −1,−1,−1,−2 → (1,−2).
- avg_log=7, ch2 all 131071 (max) ×128 → (2,131071), no wrap; all −131072 → (2,−131072).
- ready_in=0, avg_log=0, 5 strobes with A/B → first 8 results held, 9th/10th dropped, overflow_out=1; then ready_in=1 → 8 words in push order.
- chan_a_in=chan_b_in=3 strobe → only lane A data emitted, collision_out=1; avg_update_in clears it.
- avg_update_in mid-window (2 of 4 samples) then 4 new samples → result uses only new samples; n_reset_in pulse mid-stream → all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC channel averager.
package adc_pkg;
  localparam int W_DATA = 18;
  localparam int N_CHAN = 8;
  localparam int W_CHS  = 3;
  localparam int W_AVG  = 3;
  localparam int W_CNT  = (1 << W_AVG) - 1;

  // Sign-extended accumulator must hold the largest window sum without wrap.
  function automatic int acc_width(input int w_data, input int w_avg);
    return w_data + (1 << w_avg) - 1;
  endfunction

  localparam int W_ACC = acc_width(W_DATA, W_AVG);

  typedef struct packed {
    logic [W_CHS-1:0]  chan;
    logic [W_DATA-1:0] data;
  } result_t;
endpackage

// File: rtl/sample_fifo_2w1r.sv
// Two-write / one-read first-word-fall-through FIFO; lane A has write priority.
module sample_fifo_2w1r
  import adc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk_in,
  input  logic    n_reset_in,
  input  logic    wr_a_en,
  input  result_t wr_a_data,
  input  logic    wr_b_en,
  input  result_t wr_b_data,
  output logic    wr_a_ok,
  output logic    wr_b_ok,
  output logic    rd_valid,
  output result_t rd_data,
  input  logic    rd_ready
);
  localparam int AW = $clog2(DEPTH);

  result_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            pop;
  logic [AW+1:0]   free;

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // A slot vacated by this cycle's pop is usable by this cycle's writes.
  always_comb begin
    pop     = rd_valid & rd_ready;
    free    = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);
    wr_a_ok = wr_a_en && (free != '0);
    wr_b_ok = wr_b_en && (free > (AW+2)'(wr_a_ok));
  end

  always_ff @(posedge clk_in) begin
    if (wr_a_ok) mem[wr_ptr] <= wr_a_data;
    if (wr_b_ok) mem[wr_ptr + AW'(wr_a_ok)] <= wr_b_data;
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_a_ok) + AW'(wr_b_ok);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(wr_a_ok) + (AW+1)'(wr_b_ok) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/adc_chan_avg.sv
// Per-channel decimating averager for the dual-lane ADC stream; results of both
// lanes are serialized through a 2-write FIFO onto one valid/ready stream.
module adc_chan_avg
  import adc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     n_reset_in,
  input  logic                     data_valid_in,
  input  logic        [W_CHS-1:0]  chan_a_in,
  input  logic        [W_CHS-1:0]  chan_b_in,
  input  logic signed [W_DATA-1:0] data_a_in,
  input  logic signed [W_DATA-1:0] data_b_in,
  input  logic        [W_AVG-1:0]  avg_log_in,
  input  logic                     avg_update_in,
  input  logic                     ready_in,
  output logic                     data_valid_out,
  output logic        [W_CHS-1:0]  chan_out,
  output logic signed [W_DATA-1:0] data_out,
  output logic                     overflow_out,
  output logic                     collision_out
);
  logic        [W_AVG-1:0] avg_log;
  logic signed [W_ACC-1:0] acc [N_CHAN];
  logic        [W_CNT-1:0] cnt [N_CHAN];

  logic        [W_CNT:0]   win_m1;
  logic signed [W_ACC-1:0] sum_a, sum_b, sh_a, sh_b;
  logic                    sample_en, lane_b_en, last_a, last_b;
  logic                    push_a, push_b, ok_a, ok_b;
  result_t                 res_a, res_b, rd_word;

  always_comb begin
    win_m1    = ((W_CNT+1)'(1) << avg_log) - (W_CNT+1)'(1);
    sample_en = data_valid_in & ~avg_update_in;
    lane_b_en = sample_en & (chan_b_in != chan_a_in);
    sum_a     = acc[chan_a_in] + $signed({{(W_ACC-W_DATA){data_a_in[W_DATA-1]}}, data_a_in});
    sum_b     = acc[chan_b_in] + $signed({{(W_ACC-W_DATA){data_b_in[W_DATA-1]}}, data_b_in});
    last_a    = (cnt[chan_a_in] == win_m1[W_CNT-1:0]);
    last_b    = (cnt[chan_b_in] == win_m1[W_CNT-1:0]);
    sh_a      = sum_a >>> avg_log;
    sh_b      = sum_b >>> avg_log;
    res_a     = '{chan: chan_a_in, data: sh_a[W_DATA-1:0]};
    res_b     = '{chan: chan_b_in, data: sh_b[W_DATA-1:0]};
    push_a    = sample_en & last_a;
    push_b    = lane_b_en & last_b;
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      avg_log       <= '0;
      overflow_out  <= 1'b0;
      collision_out <= 1'b0;
      for (int c = 0; c < N_CHAN; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else if (avg_update_in) begin
      avg_log       <= avg_log_in;
      overflow_out  <= 1'b0;
      collision_out <= 1'b0;
      for (int c = 0; c < N_CHAN; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      if (sample_en) begin
        acc[chan_a_in] <= last_a ? '0 : sum_a;
        cnt[chan_a_in] <= last_a ? '0 : cnt[chan_a_in] + W_CNT'(1);
      end
      if (lane_b_en) begin
        acc[chan_b_in] <= last_b ? '0 : sum_b;
        cnt[chan_b_in] <= last_b ? '0 : cnt[chan_b_in] + W_CNT'(1);
      end
      if (data_valid_in && (chan_a_in == chan_b_in)) collision_out <= 1'b1;
      if ((push_a && !ok_a) || (push_b && !ok_b)) overflow_out <= 1'b1;
    end
  end

  sample_fifo_2w1r #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .n_reset_in(n_reset_in),
    .wr_a_en   (push_a),
    .wr_a_data (res_a),
    .wr_b_en   (push_b),
    .wr_b_data (res_b),
    .wr_a_ok   (ok_a),
    .wr_b_ok   (ok_b),
    .rd_valid  (data_valid_out),
    .rd_data   (rd_word),
    .rd_ready  (ready_in)
  );

  assign chan_out = rd_word.chan;
  assign data_out = rd_word.data;
endmodule
